// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter.
// The master side (requesters plus the result consumer) drives the operands
// and resp_ready. The slave side (the shared adder) drives the accept strobe
// and the registered result.
interface adder_arbiter_if #(
  parameter int N = 3,
  parameter int W = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_sum;
  logic           resp_carry;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_carry
  );
endinterface

// File: rtl/adder_arbiter.sv
// One W-bit adder shared round-robin among N requesters.
// A single operation is in flight at a time. Each operation goes through
// IDLE (grant and latch operands), COMPUTE (register the sum) and RESPOND
// (hold the result until the consumer takes it).
module adder_arbiter #(
  parameter int N = 3,
  parameter int W = 4
) (
  input logic            clock,
  input logic            reset,
  adder_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  rr_next;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [IW-1:0]  op_id;
  logic [W:0]     sum_full;

  logic [2*N-1:0] dbl_valid;
  logic [N-1:0]   rot_valid;
  logic           grant_any;
  int             grant_off;
  int             grant_idx;
  logic [IW-1:0]  grant_id;
  logic           accept;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [N-1:0]   req_ready_c;

  logic           resp_valid_q;
  logic [W-1:0]   resp_sum_q;
  logic           resp_carry_q;
  logic [IW-1:0]  resp_id_q;

  // Rotate the request vector so that bit 0 lines up with rr_ptr; the first
  // set bit of the rotated vector is then the round-robin winner.
  assign dbl_valid = {bus.req_valid, bus.req_valid} >> rr_ptr;
  assign rot_valid = dbl_valid[N-1:0];

  // Priority search from rr_ptr upward with wrap; maps the offset back to an index.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
    grant_any = 1'b0;
    grant_off = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot_valid[j]) begin
        grant_any = 1'b1;
        grant_off = j;
      end
    end
    grant_idx = int'(rr_ptr) + grant_off;
    if (grant_idx >= N) grant_idx = grant_idx - N;
    grant_id = IW'(grant_idx);
  end

  // Accept only from IDLE and never while reset is asserted, so the strobe
  // drops together with the asynchronous reset rather than at the next edge.
  assign accept = !reset && (state == IDLE) && grant_any;

  // One-hot accept strobe and operand mux for the granted requester.
  always_comb begin
    sel_a       = '0;
    sel_b       = '0;
    req_ready_c = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == grant_id) begin
        sel_a          = bus.req_a[i*W +: W];
        sel_b          = bus.req_b[i*W +: W];
        req_ready_c[i] = accept;
      end
    end
  end

  // Round-robin pointer successor: one past the requester just served.
  always_comb begin
    int nxt;
    nxt = int'(op_id) + 1;
    if (nxt >= N) nxt = 0;
    rr_next = IW'(nxt);
  end

  // Sum at W+1 bits so wrap-around surfaces as a carry, never as an error.
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

  // Control FSM with the operand and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the operand registers are reset too, so the datapath never carries X out of reset.
      state        <= IDLE;
      rr_ptr       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= '0;
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            op_id <= grant_id;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          resp_sum_q   <= sum_full[W-1:0];
          resp_carry_q <= sum_full[W];
          resp_id_q    <= op_id;
          resp_valid_q <= 1'b1;
          state        <= RESPOND;
        end
        RESPOND: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr       <= rr_next;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.resp_id    = resp_id_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_adder_arbiter;
  localparam int N  = 3;
  localparam int W  = 4;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  adder_arbiter_if #(.N(N), .W(W)) bus ();

  adder_arbiter #(.N(N), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: one job in flight, with age counting edges since accept.
  bit m_busy;
  int m_age, m_ptr, m_g, m_sum, m_carry;
  int l_sum, l_carry, l_id;

  int grant_log[$];
  int grant_cyc[$];
  int rr_exp[4] = '{0, 1, 2, 0};

  logic [N-1:0]  obs_rr;
  logic          obs_rv;
  logic [W-1:0]  obs_sum;
  logic          obs_carry;
  logic [IW-1:0] obs_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_age   = 0;
    m_ptr   = 0;
    m_g     = 0;
    l_sum   = 0;
    l_carry = 0;
    l_id    = 0;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*W +: W] = W'(a);
    bus.req_b[i*W +: W] = W'(b);
  endtask

  // One clock cycle: entered at posedge+1 with inputs already set; checks at negedge.
  task automatic cycle();
    int g, s, exp_rr;
    @(negedge clock);
    obs_rr    = bus.req_ready;
    obs_rv    = bus.resp_valid;
    obs_sum   = bus.resp_sum;
    obs_carry = bus.resp_carry;
    obs_id    = bus.resp_id;
    g      = m_busy ? -1 : pick(m_ptr, bus.req_valid);
    exp_rr = (g >= 0) ? (1 << g) : 0;
    check("req_ready",  32'(obs_rr), exp_rr);
    check("resp_valid", 32'(obs_rv), 32'(m_busy && m_age >= 1));
    check("resp_sum",   32'(obs_sum), l_sum);
    check("resp_carry", 32'(obs_carry), l_carry);
    check("resp_id",    32'(obs_id), l_id);
    for (int i = 0; i < N; i++) begin
      if (obs_rr[i]) begin
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
    @(posedge clock);
    if (!m_busy) begin
      if (g >= 0) begin
        s       = int'(bus.req_a[g*W +: W]) + int'(bus.req_b[g*W +: W]);
        m_busy  = 1'b1;
        m_age   = 0;
        m_g     = g;
        m_sum   = s % (1 << W);
        m_carry = s >> W;
      end
    end else if (m_age >= 1 && bus.resp_ready) begin
      m_busy = 1'b0;
      m_ptr  = (m_g + 1) % N;
    end else begin
      if (m_age == 0) begin
        l_sum   = m_sum;
        l_carry = m_carry;
        l_id    = m_g;
      end
      m_age++;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    // Reset state, with requests pending to show the strobe is held low.
    reset          = 1'b1;
    bus.req_valid  = 3'b111;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    #7;
    check("rst_req_ready",  32'(bus.req_ready), 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_resp_sum",   32'(bus.resp_sum), 32'h0);
    check("rst_resp_carry", 32'(bus.resp_carry), 32'h0);
    check("rst_resp_id",    32'(bus.resp_id), 32'h0);
    model_reset();
    #1;
    reset         = 1'b0;
    bus.req_valid = '0;
    @(posedge clock);
    #1;

    // Single request 3+4 on requester 0.
    bus.req_valid = 3'b001;
    set_op(0, 3, 4);
    cycle();
    check("s1_grant", 32'(obs_rr), 32'h1);
    bus.req_valid = '0;
    cycle();
    check("s1_no_early_valid", 32'(obs_rv), 32'h0);
    cycle();
    check("s1_valid", 32'(obs_rv), 32'h1);
    check("s1_sum",   32'(obs_sum), 32'd7);
    check("s1_carry", 32'(obs_carry), 32'h0);
    check("s1_id",    32'(obs_id), 32'h0);

    // Overflow 9+8 on requester 2.
    bus.req_valid = 3'b100;
    set_op(2, 9, 8);
    cycle();
    bus.req_valid = '0;
    run(2);
    check("ovf_sum",   32'(obs_sum), 32'd1);
    check("ovf_carry", 32'(obs_carry), 32'h1);
    check("ovf_id",    32'(obs_id), 32'd2);

    // Round-robin with all requesters held.
    set_op(0, 1, 2);
    set_op(1, 5, 5);
    set_op(2, 15, 15);
    bus.req_valid = 3'b111;
    grant_log.delete();
    grant_cyc.delete();
    run(12);
    bus.req_valid = '0;
    check("rr_count", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, rr_exp[k]);
      if (k > 0)
        check("rr_spacing", (k < grant_cyc.size()) ? grant_cyc[k] - grant_cyc[k-1] : -1, 3);
    end

    // Backpressure on a 3+4 result, with another requester waiting.
    set_op(1, 3, 4);
    set_op(0, 5, 6);
    bus.req_valid  = 3'b011;
    bus.resp_ready = 1'b0;
    cycle();
    check("bp_grant", 32'(obs_rr), 32'h2);
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_valid", 32'(obs_rv), 32'h1);
      check("bp_sum",   32'(obs_sum), 32'd7);
      check("bp_ready", 32'(obs_rr), 32'h0);
    end
    bus.resp_ready = 1'b1;
    cycle();
    check("bp_handshake_ready", 32'(obs_rr), 32'h0);
    cycle();
    check("bp_resume_grant", 32'(obs_rr), 32'h1);
    bus.req_valid = '0;
    run(2);

    // Reset asserted between edges while in COMPUTE.
    bus.req_valid = 3'b100;
    set_op(2, 9, 9);
    cycle();
    bus.req_valid = '0;
    #1;
    reset         = 1'b1;
    bus.req_valid = 3'b111;
    #1;
    check("mid_rst_valid", 32'(bus.resp_valid), 32'h0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    check("mid_rst_sum",   32'(bus.resp_sum), 32'h0);
    model_reset();
    #1;
    reset         = 1'b0;
    bus.req_valid = '0;
    run(4);
    set_op(1, 2, 2);
    set_op(2, 1, 1);
    bus.req_valid = 3'b110;
    cycle();
    check("post_rst_grant", 32'(obs_rr), 32'h2);
    bus.req_valid = '0;
    run(2);
    check("post_rst_sum", 32'(obs_sum), 32'd4);

    // Operand change after acceptance.
    bus.req_valid = 3'b001;
    set_op(0, 3, 4);
    cycle();
    bus.req_valid = '0;
    set_op(0, 15, 4);
    cycle();
    cycle();
    check("opchg_valid", 32'(obs_rv), 32'h1);
    check("opchg_sum",   32'(obs_sum), 32'd7);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bus.req_valid  = N'($urandom_range(0, 7));
      bus.req_a      = (N*W)'($urandom);
      bus.req_b      = (N*W)'($urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameters SHALL be:
- N, default 3: number of requesters.
- W, default 4: operand and sum width.
REQ-002 Ports SHALL be as listed; there is one clock, and reset is asynchronous and active-high.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N  requester i has an operand pair pending.
- req_a  in  N*W  operand a; requester i occupies bits [i*W +: W].
- req_b  in  N*W  operand b; same packing as req_a.
- req_ready  out  N  one-hot accept strobe, combinational.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_id  out  clog2(N)  index of the requester that owns the result.
- resp_sum  out  W  (a + b) mod 2^W.
- resp_carry  out  1  carry out of bit W-1.

Function
REQ-003 The block SHALL share one W-bit adder among N requesters, with one operation in flight at a time.
REQ-004 The FSM SHALL have exactly three states: IDLE, COMPUTE, RESPOND.
REQ-005 In IDLE with req_valid != 0, the block SHALL grant g, the first set bit of req_valid found by searching upward from rr_ptr with wrap.
- On grant: req_ready[g]=1 in that same cycle.
- Latch req_a[g], req_b[g] and g into operand registers.
- Next state: COMPUTE.
REQ-006 In IDLE with req_valid == 0, req_ready SHALL be 0 and the state SHALL stay IDLE.
REQ-007 req_ready SHALL be 0 in COMPUTE and in RESPOND.
REQ-008 In COMPUTE, the block SHALL register the adder output into resp_sum/resp_carry, set resp_id=g, and go to RESPOND.
REQ-009 In RESPOND, resp_valid SHALL be 1, and resp_sum, resp_carry and resp_id SHALL be held stable until resp_ready=1.
REQ-010 On the RESPOND cycle with resp_ready=1:
- Next state: IDLE.
- rr_ptr = (g+1) mod N.
- resp_valid drops on the next cycle.
REQ-011 Latency SHALL be fixed:
- Accept at cycle T.
- resp_valid first asserts at T+2.
- The earliest next accept is the cycle after the RESPOND handshake.
- Maximum throughput is one operation per 3 cycles.
REQ-012 The sum SHALL be computed at W+1 bits: resp_sum takes the low W bits and resp_carry takes bit W, so wrap-around is never an error.
REQ-013 Arbitration SHALL be fair: a continuously asserted req_valid[i] is granted within N grants.
REQ-014 A requester that drops req_valid before it is granted SHALL lose nothing and cause no state change.
REQ-015 Changes to req_a/req_b after acceptance SHALL NOT affect the in-flight result.
REQ-016 resp_ready asserted outside RESPOND SHALL be ignored.
REQ-017 The arbiter SHALL never accept a request while resp_valid=1.

Reset
REQ-018 reset=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE and rr_ptr=0.
- resp_valid=0, resp_sum=0, resp_carry=0, resp_id=0.
- req_ready=0.
REQ-019 A reset asserted during COMPUTE or RESPOND SHALL discard the in-flight operation, and no response for it SHALL ever appear.
REQ-020 The first rising clock edge after reset deasserts SHALL evaluate IDLE normally, with rr_ptr=0.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single request: req_valid=001, a0=3, b0=4, resp_ready=1.
  Required: req_ready=001 at T; resp_valid at T+2 with resp_sum=7, resp_carry=0, resp_id=0.
- Overflow: a=9, b=8 on requester 2.
  Required: resp_sum=1, resp_carry=1, resp_id=2.
- Round-robin: req_valid=111 held, resp_ready=1.
  Required: grant order 0,1,2,0; each grant spaced 3 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles in RESPOND with result 7.
  Required: resp_valid and resp_sum=7 stable throughout; no req_ready asserted; accept resumes the cycle after resp_ready=1.
- Reset mid-op: assert reset in COMPUTE, between clock edges.
  Required: resp_valid=0 immediately; no response appears afterward; the next grant goes to the lowest-index active requester.
- Operand change: modify req_a[0] to 15 the cycle after acceptance of 3+4.
  Required: resp_sum is still 7.
